// File: rtl/combined_memory_ext.sv
// A/D/A* memory unit: address register, selectable data registers and a
// registered RAM read of A with same-address write forwarding.
package combined_memory_ext_pkg;
    typedef struct packed {
        logic a;
        logic d;
        logic a_star;
    } dst_flag_t;
endpackage

module combined_memory_ext
    import combined_memory_ext_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_D = 2,
    localparam int DSW = (NUM_D > 1) ? $clog2(NUM_D) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  dst_flag_t        dst,
    input  logic [DSW-1:0]   d_sel,
    input  logic [1:0]       a_mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A_star,
    output logic             a_star_valid
);

    localparam logic [1:0] MODE_INC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [WIDTH-1:0] d_regs [NUM_D];
    logic [WIDTH-1:0] a_next;
    logic [ADDR_WIDTH-1:0] raddr;
    logic mem_wr;
    logic d_wr;
    logic d_in_range;

    assign raddr = A[ADDR_WIDTH-1:0];
    assign mem_wr = valid_in & dst.a_star;
    assign d_in_range = 32'(d_sel) < NUM_D;
    assign d_wr = valid_in & dst.d & d_in_range;

    // Load beats post-modify; reserved mode 11 leaves A alone.
    always_comb begin
        a_next = A;
        if (valid_in) begin
            if (dst.a) begin
                a_next = x;
            end else if (a_mode == MODE_INC) begin
                a_next = A + ONE;
            end else if (a_mode == MODE_DEC) begin
                a_next = A - ONE;
            end
        end
    end

    always_comb begin
        D = '0;
        if (d_in_range) begin
            D = d_regs[d_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[raddr] <= x;
        end
    end

    // A write to the address being read wins over the stale RAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A <= '0;
            A_star <= '0;
            a_star_valid <= 1'b0;
        end else begin
            A <= a_next;
            A_star <= mem_wr ? x : mem[raddr];
            a_star_valid <= (a_next == A);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_D; i++) begin
                d_regs[i] <= '0;
            end
        end else if (d_wr) begin
            for (int i = 0; i < NUM_D; i++) begin
                if (32'(d_sel) == i) begin
                    d_regs[i] <= x;
                end
            end
        end
    end

endmodule
